// File: rtl/dual_port_mem.sv
// dual_port_mem: two-port (I and D) synchronous word memory with per-bit
// write masks and an independent RD_LATENCY-deep read pipeline per port.
//
// Optional feature macro: DUAL_PORT_MEM_FWD_EN
//   undefined : a read that meets a same-cycle write from the other port to
//               the same word returns the pre-write contents (read-first).
//   defined   : that read returns the post-write contents (write-first),
//               including the I-then-D mask merge of a same-word collision.
//
// Ports
//   clk                 single clock, rising edge
//   nrst                asynchronous active-low reset (control only; array kept)
//   i_ncs / d_ncs       chip select, active-low
//   i_nwe / d_nwe       write enable, active-low (1 = read when selected)
//   i_addr / d_addr     byte address, ADDR_WIDTH bits
//   i_wdata / d_wdata   write data
//   i_wmask / d_wmask   per-bit write mask, 1 = bit written
//   i_rdata / d_rdata   read data, all zeros whenever rvalid is low
//   i_rvalid / d_rvalid one-cycle pulse RD_LATENCY cycles after the read edge
module dual_port_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_ncs,
    input  logic                  i_nwe,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_wmask,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_ncs,
    input  logic                  d_nwe,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_wmask,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH);

    function automatic logic [DATA_WIDTH-1:0] mask_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] i_word, d_word;
    logic [IDX_W-1:0]      i_idx, d_idx;
    logic                  unused_addr;

    // Word index drops the byte offset; keeping only IDX_W bits wraps
    // out-of-range addresses onto the array.
    assign i_word      = i_addr >> OFF_W;
    assign d_word      = d_addr >> OFF_W;
    assign i_idx       = i_word[IDX_W-1:0];
    assign d_idx       = d_word[IDX_W-1:0];
    assign unused_addr = ^{i_word, d_word};

    logic i_we, i_re, d_we, d_re, same_word;

    // Requests presented while reset is asserted are dropped.
    assign i_we      = nrst & ~i_ncs & ~i_nwe;
    assign i_re      = nrst & ~i_ncs &  i_nwe;
    assign d_we      = nrst & ~d_ncs & ~d_nwe;
    assign d_re      = nrst & ~d_ncs &  d_nwe;
    assign same_word = (i_idx == d_idx);

    logic [DATA_WIDTH-1:0] i_wword_d, d_wword_d;
    logic [DATA_WIDTH-1:0] i_rword_d, d_rword_d;

    // On a same-word collision the D merge starts from the I-merged word,
    // so D wins overlapping bits and both ports' other bits survive.
    assign i_wword_d = mask_merge(mem_q[i_idx], i_wdata, i_wmask);
    assign d_wword_d = mask_merge((i_we && same_word) ? i_wword_d : mem_q[d_idx],
                                  d_wdata, d_wmask);

`ifdef DUAL_PORT_MEM_FWD_EN
    // A port cannot read and write in the same cycle, so only the other
    // port's write can be forwarded into a read.
    assign i_rword_d = (d_we && same_word) ? d_wword_d : mem_q[i_idx];
    assign d_rword_d = (i_we && same_word) ? i_wword_d : mem_q[d_idx];
`else
    assign i_rword_d = mem_q[i_idx];
    assign d_rword_d = mem_q[d_idx];
`endif

    // Array write: contents are never reset and persist across nrst.
    always_ff @(posedge clk) begin
        if (i_we && !(d_we && same_word)) begin
            mem_q[i_idx] <= i_wword_d;
        end
        if (d_we) begin
            mem_q[d_idx] <= d_wword_d;
        end
    end

    logic [RD_LATENCY-1:0] i_vld_q, d_vld_q;
    logic [DATA_WIDTH-1:0] i_data_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] d_data_q [RD_LATENCY];

    // Read pipeline control: stage 0 loads at the accepting edge; reset
    // discards every in-flight read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i_vld_q <= '0;
            d_vld_q <= '0;
        end else begin
            i_vld_q[0] <= i_re;
            d_vld_q[0] <= d_re;
            for (int k = 1; k < RD_LATENCY; k++) begin
                i_vld_q[k] <= i_vld_q[k-1];
                d_vld_q[k] <= d_vld_q[k-1];
            end
        end
    end

    // Read pipeline data: captured at the accepting edge, so later writes
    // cannot disturb a read already in flight.
    always_ff @(posedge clk) begin
        if (i_re) begin
            i_data_q[0] <= i_rword_d;
        end
        if (d_re) begin
            d_data_q[0] <= d_rword_d;
        end
        for (int k = 1; k < RD_LATENCY; k++) begin
            i_data_q[k] <= i_data_q[k-1];
            d_data_q[k] <= d_data_q[k-1];
        end
    end

    // Output stage: data is forced to zero whenever the valid bit is low.
    assign i_rvalid = i_vld_q[RD_LATENCY-1];
    assign d_rvalid = d_vld_q[RD_LATENCY-1];
    assign i_rdata  = i_rvalid ? i_data_q[RD_LATENCY-1] : '0;
    assign d_rdata  = d_rvalid ? d_data_q[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_dual_port_mem.sv
module tb_dual_port_mem;

    localparam int AW    = 16;
    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic          clk;
    logic          nrst;
    logic          i_ncs, i_nwe, d_ncs, d_nwe;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, i_wmask, d_wdata, d_wmask;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_rvalid, d_rvalid;

    dual_port_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .nrst(nrst),
        .i_ncs(i_ncs), .i_nwe(i_nwe), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wmask(i_wmask), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_ncs(d_ncs), .d_nwe(d_nwe), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_rvalid(d_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: plain word array plus a queue of expected read
    // returns (due cycle, data) per port.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] mem_m [DEPTH];
    rd_t           qi[$];
    rd_t           qd[$];
    logic          exp_i_vld, exp_d_vld;
    logic [DW-1:0] exp_i_data, exp_d_data;

    function automatic int idx_of(input logic [AW-1:0] a);
        return (int'(a) / (DW / 8)) % DEPTH;
    endfunction

    task automatic idle();
        i_ncs = 1'b1; i_nwe = 1'b1; i_addr = '0; i_wdata = '0; i_wmask = '0;
        d_ncs = 1'b1; d_nwe = 1'b1; d_addr = '0; d_wdata = '0; d_wmask = '0;
    endtask

    // One clock edge: update the model with the inputs seen at the edge,
    // then compute what each port must show in the cycle that follows.
    task automatic step();
        int            ii, di;
        logic [DW-1:0] pre_i, pre_d;
        rd_t           e;
        @(posedge clk);
        cyc++;
        if (!nrst) begin
            qi.delete();
            qd.delete();
        end else begin
            ii    = idx_of(i_addr);
            di    = idx_of(d_addr);
            pre_i = mem_m[ii];
            pre_d = mem_m[di];
            if (!i_ncs && !i_nwe) mem_m[ii] = (mem_m[ii] & ~i_wmask) | (i_wdata & i_wmask);
            if (!d_ncs && !d_nwe) mem_m[di] = (mem_m[di] & ~d_wmask) | (d_wdata & d_wmask);
            if (!i_ncs && i_nwe) begin
                e.due = cyc + LAT - 1;
`ifdef DUAL_PORT_MEM_FWD_EN
                e.data = mem_m[ii];
`else
                e.data = pre_i;
`endif
                qi.push_back(e);
            end
            if (!d_ncs && d_nwe) begin
                e.due = cyc + LAT - 1;
`ifdef DUAL_PORT_MEM_FWD_EN
                e.data = mem_m[di];
`else
                e.data = pre_d;
`endif
                qd.push_back(e);
            end
        end
        #1;
        exp_i_vld = 1'b0; exp_i_data = '0;
        exp_d_vld = 1'b0; exp_d_data = '0;
        if (qi.size() > 0 && qi[0].due == cyc) begin
            exp_i_vld = 1'b1; exp_i_data = qi[0].data; void'(qi.pop_front());
        end
        if (qd.size() > 0 && qd[0].due == cyc) begin
            exp_d_vld = 1'b1; exp_d_data = qd[0].data; void'(qd.pop_front());
        end
    endtask

    task automatic test_reset();
        idle();
        i_ncs = 1'b0; d_ncs = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (i_rvalid !== 1'b0 || i_rdata !== '0) begin
                failures++;
                $display("FAIL reset_i rvalid=%b rdata=%h expected 0/0", i_rvalid, i_rdata);
            end
            checks++;
            if (d_rvalid !== 1'b0 || d_rdata !== '0) begin
                failures++;
                $display("FAIL reset_d rvalid=%b rdata=%h expected 0/0", d_rvalid, d_rdata);
            end
        end
        idle();
    endtask

    task automatic init_mem();
        for (int w = 0; w < DEPTH / 2; w++) begin
            idle();
            i_ncs = 1'b0; i_nwe = 1'b0; i_addr = AW'((2 * w) * 8);
            i_wdata = {$urandom, $urandom}; i_wmask = '1;
            d_ncs = 1'b0; d_nwe = 1'b0; d_addr = AW'((2 * w + 1) * 8);
            d_wdata = {$urandom, $urandom}; d_wmask = '1;
            step();
        end
        idle();
        repeat (LAT) step();
    endtask

    task automatic test_basic();
        idle(); d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0100;
        d_wdata = 64'h1122334455667788; d_wmask = '1;
        step();
        idle(); i_ncs = 1'b0; i_addr = 16'h0100;
        step();
        idle();
        for (int k = 0; k < LAT; k++) begin
            if (k > 0) step();
            checks++;
            if (k == LAT - 1) begin
                if (i_rvalid !== 1'b1 || i_rdata !== 64'h1122334455667788) begin
                    failures++;
                    $display("FAIL basic_read rvalid=%b rdata=%h expected 1/1122334455667788", i_rvalid, i_rdata);
                end
            end else if (i_rvalid !== 1'b0 || i_rdata !== '0) begin
                failures++;
                $display("FAIL basic_early k=%0d rvalid=%b rdata=%h expected 0/0", k, i_rvalid, i_rdata);
            end
        end
    endtask

    task automatic test_mask();
        idle(); i_ncs = 1'b0; i_nwe = 1'b0; i_addr = 16'h0000;
        i_wdata = '1; i_wmask = '1;
        step();
        idle(); d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0000;
        d_wdata = '0; d_wmask = 64'h00000000FFFFFFFF;
        step();
        idle(); d_ncs = 1'b0; d_addr = 16'h0000;
        step();
        idle();
        repeat (LAT - 1) step();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'hFFFFFFFF00000000) begin
            failures++;
            $display("FAIL mask_merge rvalid=%b rdata=%h expected 1/ffffffff00000000", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_collision();
        idle();
        i_ncs = 1'b0; i_nwe = 1'b0; i_addr = 16'h0200; i_wdata = {8{8'hAA}}; i_wmask = '1;
        d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0200; d_wdata = {8{8'h55}};
        d_wmask = 64'h00000000FFFFFFFF;
        step();
        idle(); i_ncs = 1'b0; i_addr = 16'h0200;
        step();
        idle();
        repeat (LAT - 1) step();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 64'hAAAAAAAA55555555) begin
            failures++;
            $display("FAIL collision rvalid=%b rdata=%h expected 1/aaaaaaaa55555555", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_pipeline();
        logic [DW-1:0] vals [3];
        int            j;
        vals[0] = 64'h0A0A0A0A00000001;
        vals[1] = 64'h0B0B0B0B00000002;
        vals[2] = 64'h0C0C0C0C00000003;
        idle();
        i_ncs = 1'b0; i_nwe = 1'b0; i_addr = 16'h0000; i_wdata = vals[0]; i_wmask = '1;
        d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0008; d_wdata = vals[1]; d_wmask = '1;
        step();
        idle(); d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0010; d_wdata = vals[2]; d_wmask = '1;
        step();
        for (int k = 0; k < LAT + 4; k++) begin
            idle();
            if (k < 3) begin
                i_ncs = 1'b0; i_addr = AW'(k * 8);
            end
            step();
            j = k - (LAT - 1);
            checks++;
            if (j >= 0 && j < 3) begin
                if (i_rvalid !== 1'b1 || i_rdata !== vals[j]) begin
                    failures++;
                    $display("FAIL pipeline k=%0d rvalid=%b rdata=%h expected 1/%h", k, i_rvalid, i_rdata, vals[j]);
                end
            end else if (i_rvalid !== 1'b0 || i_rdata !== '0) begin
                failures++;
                $display("FAIL pipeline_idle k=%0d rvalid=%b rdata=%h expected 0/0", k, i_rvalid, i_rdata);
            end
        end
        idle();
    endtask

    task automatic test_cross_port();
        logic [DW-1:0] want;
`ifdef DUAL_PORT_MEM_FWD_EN
        want = 64'h0000000000001234;
`else
        want = 64'h0;
`endif
        idle(); d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0300; d_wdata = '0; d_wmask = '1;
        step();
        idle();
        d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 16'h0300; d_wdata = 64'h1234; d_wmask = '1;
        i_ncs = 1'b0; i_addr = 16'h0300;
        step();
        idle();
        repeat (LAT - 1) step();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== want) begin
            failures++;
            $display("FAIL cross_port rvalid=%b rdata=%h expected 1/%h", i_rvalid, i_rdata, want);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] v;
        v = 64'hDEADBEEF0BADF00D;
        idle(); i_ncs = 1'b0; i_nwe = 1'b0; i_addr = 16'h0400; i_wdata = v; i_wmask = '1;
        step();
        idle(); i_ncs = 1'b0; i_addr = 16'h0400; d_ncs = 1'b0; d_addr = 16'h0400;
        step();
        idle();
        #2 nrst = 1'b0;
        qi.delete(); qd.delete();
        #1;
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== '0 || d_rvalid !== 1'b0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs i=%b/%h d=%b/%h expected all 0",
                     i_rvalid, i_rdata, d_rvalid, d_rdata);
        end
        step();
        nrst = 1'b1;
        for (int k = 0; k < LAT + 1; k++) begin
            step();
            checks++;
            if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
                failures++;
                $display("FAIL reset_mid_discard k=%0d i=%b/%h d=%b/%h expected all 0",
                         k, i_rvalid, i_rdata, d_rvalid, d_rdata);
            end
        end
        idle(); d_ncs = 1'b0; d_addr = 16'h0400;
        step();
        idle();
        repeat (LAT - 1) step();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== v) begin
            failures++;
            $display("FAIL reset_mid_persist rvalid=%b rdata=%h expected 1/%h", d_rvalid, d_rdata, v);
        end
    endtask

    function automatic logic [DW-1:0] rand_mask();
        logic [DW-1:0] m;
        case ($urandom_range(0, 3))
            0:       m = '1;
            1:       m = '0;
            2:       m = {$urandom, $urandom};
            default: m = DW'(64'hFF) << (8 * $urandom_range(0, 7));
        endcase
        return m;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            i_ncs   = ($urandom_range(0, 4) == 0);
            i_nwe   = 1'($urandom_range(0, 1));
            i_addr  = AW'($urandom);
            i_wdata = {$urandom, $urandom};
            i_wmask = rand_mask();
            d_ncs   = ($urandom_range(0, 4) == 0);
            d_nwe   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0)
                d_addr = i_addr ^ AW'(($urandom_range(0, 31) << 11) | $urandom_range(0, 7));
            else
                d_addr = AW'($urandom);
            d_wdata = {$urandom, $urandom};
            d_wmask = rand_mask();
            step();
            checks++;
            if (i_rvalid !== exp_i_vld || i_rdata !== exp_i_data) begin
                failures++;
                $display("FAIL rand_i cyc=%0d rvalid=%b rdata=%h expected %b/%h",
                         cyc, i_rvalid, i_rdata, exp_i_vld, exp_i_data);
            end
            checks++;
            if (d_rvalid !== exp_d_vld || d_rdata !== exp_d_data) begin
                failures++;
                $display("FAIL rand_d cyc=%0d rvalid=%b rdata=%h expected %b/%h",
                         cyc, d_rvalid, d_rdata, exp_d_vld, exp_d_data);
            end
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        idle();
        test_reset();
        #2 nrst = 1'b1;
        init_mem();
        test_basic();
        test_mask();
        test_collision();
        test_pipeline();
        test_cross_port();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
